uart_cmd_sequencer: RTL and testbench

//  Parametrised, synthesizable host-command sequencer that drives UART_comm_mstr's cmd/send_cmd/resp interface.

---
 rtl/uart_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// Script-replay engine for UART_comm_mstr: sends stored commands, checks responses, counts pass/fail/timeouts.
// Optional build macro CMD_SEQ_STOP_ON_FAIL_EN ends the run at the first failing entry.
module uart_cmd_sequencer #(
    parameter int CMD_W   = 24,
    parameter int RESP_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TMO_CYC = 65536,
    parameter int CNT_W   = 8,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [CMD_W-1:0]  load_cmd,
    input  logic [RESP_W-1:0] load_exp,
    input  logic              load_chk,
    input  logic [AW:0]       num_cmds,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CMD_W-1:0]  cmd,
    output logic              send_cmd,
    input  logic              cmd_sent,
    input  logic              resp_rdy,
    input  logic [RESP_W-1:0] resp,
    output logic              clr_resp_rdy,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [AW-1:0]     fail_idx,
    output logic              tmo_err,
    output logic [3:0]        dbg_state
);

    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_SENT, S_WAIT_RESP,
        S_CHECK, S_FAIL, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CMD_W-1:0]  tbl_cmd [DEPTH];
    logic [RESP_W-1:0] tbl_exp [DEPTH];
    logic              tbl_chk [DEPTH];

    logic [AW-1:0]     idx;
    logic [AW:0]       num_r;
    logic [AW:0]       num_clamped;
    logic [RESP_W-1:0] exp_r;
    logic [RESP_W-1:0] resp_r;
    logic              chk_r;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_hit;
    logic              entry_ok;
    logic              last_entry;

    assign num_clamped = (num_cmds > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_cmds;
    assign tmo_hit     = (tmo_cnt == TW'(TMO_CYC - 1));
    assign entry_ok    = !chk_r || (resp_r == exp_r);
    assign last_entry  = ({1'b0, idx} == (num_r - (AW+1)'(1)));
    assign dbg_state   = state;

    // Handshakes with the UART master are single-cycle pulses: send_cmd asks for one
    // transmission, cmd_sent/resp_rdy are only honoured in the waiting states, and
    // clr_resp_rdy pulses exactly once per consumed response (resp captured on entry to CHECK).
    always_comb begin
        state_nxt    = state;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        send_cmd     = (state == S_SEND);
        clr_resp_rdy = (state == S_CHECK);
        case (state)
            S_IDLE:      if (start) state_nxt = (num_clamped == '0) ? S_DONE : S_LOAD;
            S_LOAD:      state_nxt = S_SEND;
            S_SEND:      state_nxt = S_WAIT_SENT;
            S_WAIT_SENT: if (cmd_sent) state_nxt = resp_rdy ? S_CHECK : S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (resp_rdy)     state_nxt = S_CHECK;
                else if (tmo_hit) state_nxt = S_FAIL;
            end
            S_CHECK:     state_nxt = entry_ok ? S_NEXT : S_FAIL;
`ifdef CMD_SEQ_STOP_ON_FAIL_EN
            S_FAIL:      state_nxt = S_DONE;
`else
            S_FAIL:      state_nxt = S_NEXT;
`endif
            S_NEXT:      state_nxt = last_entry ? S_DONE : S_LOAD;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Script table has no reset; writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (load_we && state == S_IDLE && int'(load_addr) < DEPTH) begin
            tbl_cmd[load_addr] <= load_cmd;
            tbl_exp[load_addr] <= load_exp;
            tbl_chk[load_addr] <= load_chk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cmd      <= '0;
            idx      <= '0;
            num_r    <= '0;
            exp_r    <= '0;
            resp_r   <= '0;
            chk_r    <= 1'b0;
            tmo_cnt  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            fail_idx <= '0;
            tmo_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (start) begin
                    idx      <= '0;
                    num_r    <= num_clamped;
                    pass_cnt <= '0;
                    fail_cnt <= '0;
                    fail_idx <= '0;
                    tmo_err  <= 1'b0;
                end
                S_LOAD: begin
                    cmd   <= tbl_cmd[idx];
                    exp_r <= tbl_exp[idx];
                    chk_r <= tbl_chk[idx];
                end
                S_WAIT_SENT: begin
                    tmo_cnt <= '0;
                    if (cmd_sent && resp_rdy) resp_r <= resp;
                end
                S_WAIT_RESP: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (resp_rdy)     resp_r  <= resp;
                    else if (tmo_hit) tmo_err <= 1'b1;
                end
                S_CHECK: if (entry_ok && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                S_FAIL: begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                    // A saturated counter never returns to zero, so zero means "no failure yet".
                    if (fail_cnt == '0) fail_idx <= idx;
                end
                S_NEXT: if (!last_entry) idx <= idx + AW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: a UART-master responder plus a script-level reference model.
// Honours CMD_SEQ_STOP_ON_FAIL_EN in the model when the build defines it.
module tb_uart_cmd_sequencer;
  localparam int CMD_W = 24, RESP_W = 8, DEPTH = 16, TMO_CYC = 100, CNT_W = 8, AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [CMD_W-1:0] load_cmd = '0;
  logic [RESP_W-1:0] load_exp = '0;
  logic load_chk = 1'b0;
  logic [AW:0] num_cmds = '0;
  logic start = 1'b0;
  logic busy, done, send_cmd, clr_resp_rdy, tmo_err;
  logic [CMD_W-1:0] cmd;
  logic cmd_sent, resp_rdy;
  logic [RESP_W-1:0] resp;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [AW-1:0] fail_idx;
  logic [3:0] dbg_state;

  uart_cmd_sequencer #(.CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_cmd(load_cmd),
    .load_exp(load_exp), .load_chk(load_chk), .num_cmds(num_cmds), .start(start), .busy(busy),
    .done(done), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy),
    .resp(resp), .clr_resp_rdy(clr_resp_rdy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_idx(fail_idx), .tmo_err(tmo_err), .dbg_state(dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

`ifdef CMD_SEQ_STOP_ON_FAIL_EN
  bit stop_on_fail = 1'b1;
`else
  bit stop_on_fail = 1'b0;
`endif

  // script entries and how the fake UART answers each one
  logic [CMD_W-1:0] e_cmd [DEPTH];
  logic [RESP_W-1:0] e_exp [DEPTH];
  logic [RESP_W-1:0] e_rsp [DEPTH];
  bit e_chk [DEPTH];
  bit e_norsp [DEPTH];
  bit same_cyc = 1'b0;
  int max_dly = 2;

  logic [CMD_W-1:0] exp_q[$];
  int sends_total = 0;
  int run_base = 0;
  int sent_cycle = 0;
  int n_checks = 0;
  int n_fail = 0;
  int m_pass, m_fail, m_fidx;
  bit m_tmo;
  int r_done, r_done_at, r_lat, r_tmo_at;

  // fake UART master; also the command scoreboard
  initial begin : responder
    int ent;
    int k;
    logic [CMD_W-1:0] exp_c;
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    resp = '0;
    forever begin
      @(negedge clk);
      if (send_cmd === 1'b1) begin
        ent = (sends_total - run_base) % DEPTH;
        sends_total++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sb_cmd unexpected send_cmd cmd=%06h", cmd);
        end else begin
          exp_c = exp_q.pop_front();
          if (cmd !== exp_c) begin n_fail++; $display("FAIL sb_cmd got=%06h exp=%06h", cmd, exp_c); end
        end
        @(negedge clk);
        repeat ($urandom_range(0, max_dly)) @(negedge clk);
        cmd_sent = 1'b1;
        sent_cycle = cycle;
        if (same_cyc && !e_norsp[ent]) begin resp = e_rsp[ent]; resp_rdy = 1'b1; end
        @(negedge clk);
        cmd_sent = 1'b0;
        if (!e_norsp[ent]) begin
          if (!resp_rdy) begin
            repeat ($urandom_range(0, max_dly)) @(negedge clk);
            resp = e_rsp[ent];
            resp_rdy = 1'b1;
            @(negedge clk);
          end
          k = 0;
          while (clr_resp_rdy !== 1'b1 && k < 50) begin @(negedge clk); k++; end
          resp_rdy = 1'b0;
          resp = RESP_W'($urandom);
        end
      end
    end
  end

  // reference model: outcome of a whole run from the script rules
  task automatic model(input int num);
    int n;
    n = (num > DEPTH) ? DEPTH : num;
    m_pass = 0; m_fail = 0; m_fidx = 0; m_tmo = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(e_cmd[i]);
      if (e_norsp[i]) m_tmo = 1'b1;
      if (!e_norsp[i] && (!e_chk[i] || e_rsp[i] == e_exp[i])) m_pass++;
      else begin
        if (m_fail == 0) m_fidx = i;
        m_fail++;
        if (stop_on_fail) break;
      end
    end
  endtask

  // driver tasks
  task automatic load_table(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_we = 1'b1; load_addr = AW'(i); load_cmd = e_cmd[i]; load_exp = e_exp[i]; load_chk = e_chk[i];
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic run_script(input int num, input int inject_at);
    int cyc;
    int limit;
    bit fin;
    r_done = 0; r_done_at = -1; r_lat = -1; r_tmo_at = -1;
    run_base = sends_total;
    limit = 60 + ((num > DEPTH) ? DEPTH : num) * (TMO_CYC + 40);
    @(negedge clk);
    num_cmds = (AW+1)'(num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_cmds = (AW+1)'($urandom);
    cyc = 1;
    fin = 1'b0;
    while (!fin && cyc < limit) begin
      if (cyc == inject_at) begin
        start = 1'b1; num_cmds = '0;
        load_we = 1'b1; load_addr = AW'(num - 1); load_cmd = ~e_cmd[num - 1]; load_exp = ~e_exp[num - 1]; load_chk = 1'b1;
      end else begin
        start = 1'b0; load_we = 1'b0;
      end
      if (send_cmd === 1'b1 && r_lat < 0) r_lat = cyc;
      if (tmo_err === 1'b1 && r_tmo_at < 0) r_tmo_at = cycle;
      if (done === 1'b1) begin r_done++; r_done_at = cyc; fin = 1'b1; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    load_we = 1'b0;
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL run_bound no done within %0d cycles", limit); end
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) r_done++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_missing got=%0d unsent exp=0", exp_q.size()); end
  endtask

  task automatic set_basic();
    for (int i = 0; i < DEPTH; i++) begin
      e_cmd[i] = CMD_W'($urandom); e_exp[i] = 8'hA5; e_rsp[i] = 8'hA5; e_chk[i] = 1'b1; e_norsp[i] = 1'b0;
    end
    e_cmd[0] = 24'h020000; e_cmd[1] = 24'h03002E; e_cmd[2] = 24'h040134;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (send_cmd !== 1'b0 || clr_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", send_cmd, clr_resp_rdy); end
    n_checks++; if (cmd !== '0) begin n_fail++; $display("FAIL reset_cmd got=%06h exp=0", cmd); end
    n_checks++; if (pass_cnt !== '0 || fail_cnt !== '0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
    n_checks++; if (fail_idx !== '0 || tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_fidx_tmo got=%0d/%b exp=0/0", fail_idx, tmo_err); end
  endtask

  task automatic test_basic();
    set_basic();
    load_table(3);
    model(3);
    run_script(3, -1);
    n_checks++; if (pass_cnt !== 8'd3) begin n_fail++; $display("FAIL basic_pass got=%0d exp=3", pass_cnt); end
    n_checks++; if (fail_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_fail got=%0d exp=0", fail_cnt); end
    n_checks++; if (r_done !== 1) begin n_fail++; $display("FAIL basic_done_cnt got=%0d exp=1", r_done); end
    n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL basic_start_to_send got=%0d exp=2", r_lat); end
    n_checks++; if (cmd !== 24'h040134) begin n_fail++; $display("FAIL basic_cmd_hold got=%06h exp=040134", cmd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_mismatch();
    set_basic();
    e_rsp[1] = 8'hEE;
    load_table(3);
    model(3);
    run_script(3, -1);
    n_checks++; if (pass_cnt !== CNT_W'(m_pass)) begin n_fail++; $display("FAIL mism_pass got=%0d exp=%0d", pass_cnt, m_pass); end
    n_checks++; if (fail_cnt !== 8'd1) begin n_fail++; $display("FAIL mism_fail got=%0d exp=1", fail_cnt); end
    n_checks++; if (fail_idx !== 4'd1) begin n_fail++; $display("FAIL mism_fidx got=%0d exp=1", fail_idx); end
    n_checks++; if (r_done !== 1) begin n_fail++; $display("FAIL mism_done_cnt got=%0d exp=1", r_done); end
  endtask

  task automatic test_eep();
    set_basic();
    e_cmd[0] = 24'h080012; e_chk[0] = 1'b0; e_exp[0] = 8'h00; e_rsp[0] = 8'h34;
    e_cmd[1] = 24'h080012; e_chk[1] = 1'b1; e_exp[1] = 8'h34; e_rsp[1] = 8'h34;
    e_cmd[2] = 24'h080012; e_chk[2] = 1'b1; e_exp[2] = 8'h35; e_rsp[2] = 8'h34;
    same_cyc = 1'b1;
    load_table(3);
    model(3);
    run_script(3, -1);
    same_cyc = 1'b0;
    n_checks++; if (pass_cnt !== 8'd2) begin n_fail++; $display("FAIL eep_pass got=%0d exp=2", pass_cnt); end
    n_checks++; if (fail_cnt !== 8'd1 || fail_idx !== 4'd2) begin n_fail++; $display("FAIL eep_fail got=%0d@%0d exp=1@2", fail_cnt, fail_idx); end
  endtask

  task automatic test_timeout();
    set_basic();
    e_norsp[0] = 1'b1;
    load_table(1);
    model(1);
    run_script(1, -1);
    n_checks++; if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag got=%b exp=1", tmo_err); end
    n_checks++; if (fail_cnt !== 8'd1 || pass_cnt !== 8'd0) begin n_fail++; $display("FAIL tmo_counts got=%0d/%0d exp=0/1", pass_cnt, fail_cnt); end
    n_checks++;
    if (r_tmo_at - sent_cycle < TMO_CYC || r_tmo_at - sent_cycle > TMO_CYC + 1) begin
      n_fail++; $display("FAIL tmo_latency got=%0d exp=%0d..%0d", r_tmo_at - sent_cycle, TMO_CYC, TMO_CYC + 1);
    end
  endtask

  task automatic test_zero_and_busy();
    run_script(0, -1);
    n_checks++; if (r_done_at !== 1 || r_done !== 1) begin n_fail++; $display("FAIL zero_done got=%0d@%0d exp=1@1", r_done, r_done_at); end
    n_checks++; if (r_lat !== -1) begin n_fail++; $display("FAIL zero_no_send got=%0d exp=-1", r_lat); end
    n_checks++; if (pass_cnt !== '0 || fail_cnt !== '0 || tmo_err !== 1'b0) begin n_fail++; $display("FAIL zero_counts got=%0d/%0d/%b exp=0/0/0", pass_cnt, fail_cnt, tmo_err); end
    set_basic();
    load_table(3);
    model(3);
    run_script(3, 4);
    n_checks++; if (pass_cnt !== 8'd3 || r_done !== 1) begin n_fail++; $display("FAIL busy_ignore got=%0d/%0d exp=3/1", pass_cnt, r_done); end
  endtask

  task automatic test_random();
    int num;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        e_cmd[i] = CMD_W'($urandom);
        e_exp[i] = RESP_W'($urandom);
        e_chk[i] = ($urandom_range(0, 1) == 1);
        e_rsp[i] = ($urandom_range(0, 2) == 0) ? RESP_W'($urandom) : e_exp[i];
        e_norsp[i] = ($urandom_range(0, 15) == 0);
      end
      same_cyc = ($urandom_range(0, 1) == 1);
      num = (it == 0) ? 31 : $urandom_range(1, 20);
      load_table(DEPTH);
      model(num);
      run_script(num, -1);
      n_checks++; if (pass_cnt !== CNT_W'(m_pass)) begin n_fail++; $display("FAIL rnd%0d_pass got=%0d exp=%0d", it, pass_cnt, m_pass); end
      n_checks++; if (fail_cnt !== CNT_W'(m_fail)) begin n_fail++; $display("FAIL rnd%0d_fail got=%0d exp=%0d", it, fail_cnt, m_fail); end
      n_checks++; if (fail_idx !== AW'(m_fidx)) begin n_fail++; $display("FAIL rnd%0d_fidx got=%0d exp=%0d", it, fail_idx, m_fidx); end
      n_checks++; if (tmo_err !== m_tmo) begin n_fail++; $display("FAIL rnd%0d_tmo got=%b exp=%b", it, tmo_err, m_tmo); end
      n_checks++; if (r_done !== 1) begin n_fail++; $display("FAIL rnd%0d_done_cnt got=%0d exp=1", it, r_done); end
    end
    same_cyc = 1'b0;
  endtask

  task automatic test_rst_mid();
    int k;
    int extra;
    set_basic();
    e_rsp[0] = 8'hEE;
    e_norsp[1] = 1'b1;
    load_table(2);
    exp_q.delete();
    exp_q.push_back(e_cmd[0]);
    exp_q.push_back(e_cmd[1]);
    run_base = sends_total;
    @(negedge clk);
    num_cmds = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (sends_total - run_base < 2 && k < 200) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    n_checks++; if (fail_cnt !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre got=%0d/%b exp=1/1", fail_cnt, busy); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++; if (fail_cnt !== '0 || pass_cnt !== '0 || cmd !== '0) begin n_fail++; $display("FAIL rst_values got=%0d/%0d/%06h exp=0/0/0", pass_cnt, fail_cnt, cmd); end
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      if (done === 1'b1 || clr_resp_rdy === 1'b1) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rst_no_pulses got=%0d exp=0", extra); end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_mismatch();
    test_zero_and_busy();
    test_eep();
    test_timeout();
    test_random();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
